// File: rtl/fifo_drain_framer_if.sv
// ----------------------------------------------------------------------------
// fifo_drain_framer_if
//   Output beat stream of the FIFO drain framer.
//
//   Handshake: a beat transfers on every rising clock edge where valid and
//   ready are both 1. While valid=1 and ready=0 the source keeps valid, data
//   and last unchanged. The source never waits for ready before raising
//   valid.
//
//   Signals:
//     valid  source -> sink  beat valid
//     data   source -> sink  beat payload (WIDTH bits)
//     last   source -> sink  final beat of the current frame
//     ready  sink -> source  sink accepts the beat
//
//   Modports: master = framer side, slave = downstream consumer.
// ----------------------------------------------------------------------------
interface fifo_drain_framer_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_drain_framer.sv
// ----------------------------------------------------------------------------
// fifo_drain_framer
//   Read-side consumer of a dual-clock FIFO, living in the FIFO read-clock
//   domain. Reads words from the FIFO read port without underflowing it,
//   buffers them in a 3-entry queue and emits them as a valid/ready stream
//   cut into frames of FRAME_LEN data beats, the final beat flagged by last.
//
//   Optional feature, macro DRAIN_CHECKSUM_EN:
//     undefined -> frames are exactly FRAME_LEN data beats.
//     defined   -> each frame is followed by one checksum beat (two's
//                  complement of the modulo-2^WIDTH data sum) carrying last;
//                  frames become FRAME_LEN+1 beats.
//
//   Parameters:
//     WIDTH      data word width (matches the FIFO width)
//     FRAME_LEN  data beats per frame, 2..255
//
//   Ports:
//     clk         clock (FIFO rd_clk)
//     res         asynchronous active-high reset
//     fifo_empty  FIFO empty flag
//     fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en  FIFO read request (combinational)
//     out         output stream (fifo_drain_framer_if.master)
//     frame_cnt   completed frames, wraps at 2^16
//     dbg_state   framing FSM state (1 = checksum beat); 0 when the
//                 checksum feature is not built
// ----------------------------------------------------------------------------
module fifo_drain_framer #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       fifo_empty,
    input  logic [WIDTH-1:0]           fifo_rdata,
    output logic                       fifo_rd_en,
    fifo_drain_framer_if.master        out,
    output logic [15:0]                frame_cnt,
    output logic                       dbg_state
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    // Circular queue of three words: head is the oldest entry, occ the fill.
    logic [WIDTH-1:0] mem [3];
    logic [1:0]       head;
    logic [1:0]       occ;
    logic             pending;   // read issued last cycle, word arrives now
    logic [7:0]       beat;      // data beats already accepted in this frame

    logic [2:0]       fill;
    logic [1:0]       tail;
    logic             data_valid;
    logic             in_csum;
    logic             accept;
    logic             pop;
    logic             last_data;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // The in-flight word is counted as occupying a slot, so a word that was
    // requested always finds room even if downstream stalls meanwhile.
    assign fill       = {1'b0, occ} + {2'b00, pending};
    assign fifo_rd_en = !res && !fifo_empty && (fill < 3'd3);

    assign tail       = wrap3({1'b0, head} + {1'b0, occ});
    assign data_valid = (occ != 2'd0);
    assign last_data  = (beat == LAST_BEAT);
    assign accept     = out.valid && out.ready;
    // The checksum beat is generated, not taken from the queue.
    assign pop        = accept && !in_csum;

`ifdef DRAIN_CHECKSUM_EN
    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CSUM = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;

    assign in_csum   = (state == ST_CSUM);
    assign dbg_state = in_csum;
    assign out.valid = data_valid || in_csum;
    assign out.data  = in_csum ? ({WIDTH{1'b0}} - acc) : mem[head];
    assign out.last  = in_csum;
`else
    assign in_csum   = 1'b0;
    assign dbg_state = 1'b0;
    assign out.valid = data_valid;
    assign out.data  = mem[head];
    assign out.last  = data_valid && last_data;
`endif

    // Outputs above decode only flops (queue head, fill, beat, state), so
    // they stay stable across a stall without any input-to-output path.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
            head      <= 2'd0;
            occ       <= 2'd0;
            pending   <= 1'b0;
            beat      <= 8'd0;
            frame_cnt <= 16'd0;
`ifdef DRAIN_CHECKSUM_EN
            state     <= ST_DATA;
            acc       <= '0;
`endif
        end else begin
            pending <= fifo_rd_en;

            if (pending) begin
                mem[tail] <= fifo_rdata;
            end

            if (pop) begin
                head <= wrap3({1'b0, head} + 3'd1);
            end

            // Capture together with pop leaves the fill unchanged.
            case ({pending, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (pop) begin
                if (last_data) begin
                    beat <= 8'd0;
`ifdef DRAIN_CHECKSUM_EN
                    state <= ST_CSUM;
`else
                    frame_cnt <= frame_cnt + 16'd1;
`endif
                end else begin
                    beat <= beat + 8'd1;
                end
`ifdef DRAIN_CHECKSUM_EN
                acc <= acc + mem[head];
`endif
            end

`ifdef DRAIN_CHECKSUM_EN
            if (in_csum && accept) begin
                state     <= ST_DATA;
                acc       <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end
`endif
        end
    end

endmodule
